// File: rtl/debounce_multi.sv
// Multi-channel push-button debouncer: two-flop synchroniser, stability filter,
// registered press/release pulses and an optional per-channel auto-repeat generator.
module debounce_multi #(
    parameter int unsigned N_CH          = 4,
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned REPEAT_EN     = 0,
    parameter int unsigned REPEAT_DELAY  = 1000,
    parameter int unsigned REPEAT_PERIOD = 250
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] db_in,
    output logic [N_CH-1:0] db_level,
    output logic [N_CH-1:0] db_rise,
    output logic [N_CH-1:0] db_fall,
    output logic [N_CH-1:0] db_rep
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);

    logic [N_CH-1:0]  s1_q;
    logic [N_CH-1:0]  s2_q;
    logic [N_CH-1:0]  level_q;
    logic [N_CH-1:0]  level_d;
    logic [N_CH-1:0]  rise_q;
    logic [N_CH-1:0]  rise_d;
    logic [N_CH-1:0]  fall_q;
    logic [N_CH-1:0]  fall_d;
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];

    // Stability filter: accept s2 only after STABLE_CYCLES consecutive mismatching samples
    always_comb begin
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            cnt_d[i] = cnt_q[i];
            if (s2_q[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_W'(STABLE_CYCLES - 1)) begin
                level_d[i] = s2_q[i];
                cnt_d[i]   = '0;
                rise_d[i]  = s2_q[i];
                fall_d[i]  = ~s2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q    <= '0;
            s2_q    <= '0;
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            for (int i = 0; i < int'(N_CH); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q    <= db_in;
            s2_q    <= s1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            for (int i = 0; i < int'(N_CH); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign db_level = level_q;
    assign db_rise  = rise_q;
    assign db_fall  = fall_q;

    if (REPEAT_EN != 0) begin : g_rep
        localparam int unsigned RMAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
        localparam int unsigned RCNT_W = $clog2(RMAX + 1);

        typedef enum logic [1:0] {
            RPT_IDLE  = 2'd0,
            RPT_DELAY = 2'd1,
            RPT_RUN   = 2'd2
        } rpt_state_e;

        rpt_state_e        state_q [N_CH];
        rpt_state_e        state_d [N_CH];
        logic [RCNT_W-1:0] rcnt_q  [N_CH];
        logic [RCNT_W-1:0] rcnt_d  [N_CH];
        logic [N_CH-1:0]   rep_q;
        logic [N_CH-1:0]   rep_d;

        always_ff @(posedge clk) begin
            if (reset) begin
                rep_q <= '0;
                for (int i = 0; i < int'(N_CH); i++) begin
                    state_q[i] <= RPT_IDLE;
                    rcnt_q[i]  <= '0;
                end
            end else begin
                rep_q <= rep_d;
                for (int i = 0; i < int'(N_CH); i++) begin
                    state_q[i] <= state_d[i];
                    rcnt_q[i]  <= rcnt_d[i];
                end
            end
        end

        // Decisions use the next-cycle level so a coincident release suppresses the repeat
        always_comb begin
            rep_d = '0;
            for (int i = 0; i < int'(N_CH); i++) begin
                state_d[i] = state_q[i];
                rcnt_d[i]  = rcnt_q[i];
                case (state_q[i])
                    RPT_IDLE: begin
                        if (rise_d[i]) begin
                            state_d[i] = RPT_DELAY;
                            rcnt_d[i]  = RCNT_W'(1);
                        end
                    end
                    RPT_DELAY: begin
                        if (!level_d[i]) begin
                            state_d[i] = RPT_IDLE;
                        end else if (rcnt_q[i] == RCNT_W'(REPEAT_DELAY)) begin
                            rep_d[i]   = 1'b1;
                            rcnt_d[i]  = RCNT_W'(1);
                            state_d[i] = RPT_RUN;
                        end else begin
                            rcnt_d[i] = rcnt_q[i] + RCNT_W'(1);
                        end
                    end
                    RPT_RUN: begin
                        if (!level_d[i]) begin
                            state_d[i] = RPT_IDLE;
                        end else if (rcnt_q[i] == RCNT_W'(REPEAT_PERIOD)) begin
                            rep_d[i]  = 1'b1;
                            rcnt_d[i] = RCNT_W'(1);
                        end else begin
                            rcnt_d[i] = rcnt_q[i] + RCNT_W'(1);
                        end
                    end
                    default: begin
                        state_d[i] = RPT_IDLE;
                    end
                endcase
            end
        end

        assign db_rep = rep_q;
    end else begin : g_norep
        assign db_rep = '0;
    end

endmodule
